apb_master_bridge: RTL and testbench

- Downstream stage of the CPU datapath. Converts the core's single-outstanding load/store requests (valid/ready) into APB transfers on the shared 16-bit apb_bus (paddr, pwrite, psel, penable, pwdata, prdata, pready).
- Returns read data and a completion/error response to the core.
- Bounds slave wait states with a timeout counter so a dead slave cannot hang the CPU.

---
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb_master_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single-outstanding core load/store requests into
// APB SETUP/ACCESS transfers and returns a one-cycle response. A wait-state
// counter aborts transfers to an unresponsive slave.
module apb_master_bridge #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    // Counter value seen during the last permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, timeout, done;

    logic              req_ready_d, rsp_valid_d, rsp_err_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [DATA_W-1:0] rsp_rdata_d, pwdata_d;
    logic [ADDR_W-1:0] paddr_d;

    assign accept  = (state_q == StIdle) && req_valid && req_ready;
    // A ready slave on the last allowed cycle wins over the abort.
    assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == StAccess) && !pready &&
                     (cnt_q == CntLast);
    assign done    = (state_q == StAccess) && (pready || timeout);

    // State and wait-state counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; the counter saturates so a disabled
    // timeout never wraps into a false abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StSetup;
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = '0;
            end
            StAccess: begin
                if (done) begin
                    state_d = StIdle;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        req_ready_d = (state_d == StIdle);
        psel_d      = (state_d != StIdle);
        penable_d   = (state_d == StAccess);
        rsp_valid_d = done;
        rsp_err_d   = done && !pready;
        rsp_rdata_d = (done && pready && !pwrite) ? prdata : '0;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        pwrite_d    = pwrite;
        if (accept) begin
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            pwrite_d = req_write;
        end
    end

    // Output register; reset drops psel/penable without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwdata    <= '0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            paddr     <= paddr_d;
            pwrite    <= pwrite_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwdata    <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with TIMEOUT_CYCLES = 16.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [15:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready;

    int n_pass  = 0;
    int n_total = 0;

    int pen_n, sel_n;
    bit seen, bad;

    apb_master_bridge #(
        .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(16), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at the SETUP sample point. Walks the transfer to the response,
    // counting psel/penable cycles and flagging any psel drop or bus change.
    // rdy_at: penable cycle on which pready is raised (0 = never).
    task automatic wait_rsp(input int rdy_at, input bit toggle, input logic [15:0] ea,
                            input logic [15:0] ed, input logic ew,
                            output int pen, output int sel, output bit got, output bit err);
        pen = 0; sel = 0; got = 0; err = 0;
        for (int i = 0; i < 40; i++) begin
            if (penable) pen++;
            if (psel) sel++;
            if (!psel) err = 1;
            if (paddr !== ea || pwdata !== ed || pwrite !== ew) err = 1;
            if (rdy_at != 0 && pen == rdy_at) pready = 1'b1;
            if (toggle) begin
                req_valid = ~req_valid;
                req_addr  = 16'h0020;
            end
            tick();
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        pready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_psel_pen", 32'({psel, penable, rsp_valid, rsp_err}), 32'h0);
        chk("rst_paddr", 32'(paddr), 32'h0);
        reset = 1'b1;
        tick();
        chk("ready_after_rst", 32'(req_ready), 32'h1);

        // 1: read, zero wait states
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040; req_wdata = 16'h0000;
        tick();
        req_valid = 1'b0;
        chk("t1_setup", 32'({psel, penable, req_ready}), 32'h4);
        prdata = 16'hBEEF;
        wait_rsp(1, 1'b0, 16'h0040, 16'h0000, 1'b0, pen_n, sel_n, seen, bad);
        chk("t1_seen", 32'(seen), 32'h1);
        chk("t1_psel_n", 32'(sel_n), 32'd2);
        chk("t1_pen_n", 32'(pen_n), 32'd1);
        chk("t1_rdata", 32'(rsp_rdata), 32'hBEEF);
        chk("t1_err_ready", 32'({rsp_err, req_ready, psel, penable}), 32'h4);
        tick();
        chk("t1_pulse", 32'(rsp_valid), 32'h0);

        // 2: write, three wait states
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 16'hA5A5;
        tick();
        req_valid = 1'b0;
        wait_rsp(4, 1'b0, 16'h1234, 16'hA5A5, 1'b1, pen_n, sel_n, seen, bad);
        chk("t2_seen", 32'(seen), 32'h1);
        chk("t2_stable", 32'(bad), 32'h0);
        chk("t2_pen_n", 32'(pen_n), 32'd4);
        chk("t2_rdata_err", 32'({rsp_rdata, 3'b000, rsp_err}), 32'h0);

        // 3: timeout, slave never ready
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0300; req_wdata = 16'h0000;
        prdata = 16'h7777;
        tick();
        req_valid = 1'b0;
        wait_rsp(0, 1'b0, 16'h0300, 16'h0000, 1'b0, pen_n, sel_n, seen, bad);
        chk("t3_seen", 32'(seen), 32'h1);
        chk("t3_pen_n", 32'(pen_n), 32'd16);
        chk("t3_err", 32'(rsp_err), 32'h1);
        chk("t3_rdata", 32'(rsp_rdata), 32'h0);
        chk("t3_ready_psel", 32'({req_ready, psel, penable}), 32'h4);

        // 3b: ready on the 16th ACCESS cycle completes normally
        tick();
        req_valid = 1'b1; req_addr = 16'h0302; prdata = 16'h5A5A;
        tick();
        req_valid = 1'b0;
        wait_rsp(16, 1'b0, 16'h0302, 16'h0000, 1'b0, pen_n, sel_n, seen, bad);
        chk("t3b_seen", 32'(seen), 32'h1);
        chk("t3b_pen_n", 32'(pen_n), 32'd16);
        chk("t3b_err", 32'(rsp_err), 32'h0);
        chk("t3b_rdata", 32'(rsp_rdata), 32'h5A5A);

        // 4: back-to-back reads with req_valid held high
        tick();
        req_valid = 1'b1; req_addr = 16'h0002; prdata = 16'h1111; pready = 1'b1;
        tick();
        req_addr = 16'h0004;
        tick();
        tick();
        chk("t4_rsp1", 32'({rsp_valid, rsp_rdata}), 32'h1_1111);
        chk("t4_rdy1", 32'(req_ready), 32'h1);
        prdata = 16'h2222;
        tick();
        req_valid = 1'b0;
        chk("t4_setup2", 32'({psel, penable, rsp_valid}), 32'h4);
        chk("t4_addr2", 32'(paddr), 32'h0004);
        tick();
        tick();
        chk("t4_rsp2", 32'({rsp_valid, rsp_rdata}), 32'h1_2222);
        pready = 1'b0;

        // 5: reset during ACCESS of a write
        tick();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0ABC; req_wdata = 16'h1357;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t5_in_access", 32'({psel, penable}), 32'h3);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_drop", 32'({psel, penable, req_ready, rsp_valid}), 32'h0);
        #1 reset = 1'b1;
        tick();
        chk("t5_ready_back", 32'({req_ready, rsp_valid}), 32'h2);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100; req_wdata = 16'h0000;
        prdata = 16'h0F0F;
        tick();
        req_valid = 1'b0;
        wait_rsp(2, 1'b0, 16'h0100, 16'h0000, 1'b0, pen_n, sel_n, seen, bad);
        chk("t5_seen", 32'(seen), 32'h1);
        chk("t5_rsp", 32'({rsp_err, rsp_rdata}), 32'h0_0F0F);

        // 6: req_valid toggling during SETUP and ACCESS is ignored
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010; prdata = 16'h3C3C;
        tick();
        req_valid = 1'b0;
        wait_rsp(3, 1'b1, 16'h0010, 16'h0000, 1'b0, pen_n, sel_n, seen, bad);
        req_valid = 1'b0;
        chk("t6_seen", 32'(seen), 32'h1);
        chk("t6_psel_held", 32'(bad), 32'h0);
        chk("t6_rsp", 32'(rsp_rdata), 32'h3C3C);
        tick();
        chk("t6_no_second", 32'({psel, penable, req_ready}), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // penable without psel is illegal at any sample point.
    always @(negedge clk) begin
        if (reset && penable && !psel) chk("pen_wo_psel", 32'(penable), 32'h0);
    end

endmodule
